// File: rtl/bitnet_pkg.sv
// -----------------------------------------------------------------------------
// bitnet_pkg
// Shared types and constants for the bitnet majority-reduction blocks.
//   maj_state_t    : control states of maj_stream_reducer
//   MAJ_TIE_VALUE  : result driven when the final tally is exactly zero
//   maj_eff_bit    : per-element inversion, same as the maj_gate control input
// -----------------------------------------------------------------------------
package bitnet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } maj_state_t;

  localparam bit MAJ_TIE_VALUE = 1'b1;

  // Effective vote of one element: the control bit inverts the data bit.
  function automatic logic maj_eff_bit(input logic data, input logic control);
    return data ^ control;
  endfunction

endpackage

// File: rtl/maj_tally_counter.sv
// -----------------------------------------------------------------------------
// maj_tally_counter
// Signed up/down counter with synchronous clear (priority) and enable.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   clr_in           : load zero
//   en_in            : count one step this cycle
//   up_in            : step direction (1 = +1, 0 = -1)
//   count_out        : registered count
//   next_out         : value count_out takes after this edge
// -----------------------------------------------------------------------------
module maj_tally_counter #(
  parameter int W = 9
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                clr_in,
  input  logic                en_in,
  input  logic                up_in,
  output logic signed [W-1:0] count_out,
  output logic signed [W-1:0] next_out
);

  localparam logic signed [W-1:0] STEP_ONE = W'(1);

  logic signed [W-1:0] count_q;
  logic signed [W-1:0] count_d;

  // Next-count selection: clear beats enable.
  always_comb begin
    count_d = count_q;
    if (clr_in) begin
      count_d = '0;
    end else if (en_in) begin
      if (up_in) begin
        count_d = count_q + STEP_ONE;
      end else begin
        count_d = count_q - STEP_ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;
  assign next_out  = count_d;

endmodule

// File: rtl/maj_stream_reducer.sv
// -----------------------------------------------------------------------------
// maj_stream_reducer
// Majority vote over a streamed vector of 1..N_MAX elements. Each element's
// effective vote is data_in ^ control_in. Produces the sign (maj_out) and the
// signed tally (#ones - #zeros) once per vector, held until accepted.
// Ports:
//   clk_in, rst_n_in          : clock, asynchronous active-low reset
//   start_in, len_in          : begin a vector of len_in elements (IDLE only)
//   s_valid_in, s_ready_out   : element handshake
//   data_in, control_in       : element data and invert control
//   m_valid_out, m_ready_in   : result handshake
//   maj_out, tally_out        : result (tally is LW+1 bit two's complement)
//   busy_out                  : high while a vector is in progress or pending
// All outputs are registered.
// -----------------------------------------------------------------------------
module maj_stream_reducer
  import bitnet_pkg::*;
#(
  parameter int N_MAX = 255,
  parameter int LW    = $clog2(N_MAX + 1)
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [LW-1:0] len_in,
  input  logic        s_valid_in,
  output logic        s_ready_out,
  input  logic        data_in,
  input  logic        control_in,
  output logic        m_valid_out,
  input  logic        m_ready_in,
  output logic        maj_out,
  output logic [LW:0] tally_out,
  output logic        busy_out
);

  maj_state_t state_q, state_d;
  logic [LW-1:0] remain_q, remain_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  logic          maj_q, maj_d;
  logic [LW:0]   tally_q, tally_d;
  logic          busy_q, busy_d;

  logic               beat_s;
  logic               eff_s;
  logic               clr_s;
  logic               en_s;
  logic signed [LW:0] count_s;
  logic signed [LW:0] next_s;

  assign beat_s = s_valid_in & s_ready_q;
  assign eff_s  = maj_eff_bit(data_in, control_in);

  maj_tally_counter #(
    .W (LW + 1)
  ) u_tally (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clr_in    (clr_s),
    .en_in     (en_s),
    .up_in     (eff_s),
    .count_out (count_s),
    .next_out  (next_s)
  );

  // FSM next state, remaining counter and output-register loads.
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    maj_d     = maj_q;
    tally_d   = tally_q;
    clr_s     = 1'b0;
    en_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in && (len_in != '0)) begin
          state_d   = ACCUM;
          remain_d  = len_in;
          clr_s     = 1'b1;
          s_ready_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s) begin
          en_s     = 1'b1;
          remain_d = remain_q - LW'(1);
          // Last beat: publish the tally including this beat's vote.
          if (remain_q == LW'(1)) begin
            state_d   = DONE;
            s_ready_d = 1'b0;
            m_valid_d = 1'b1;
            tally_d   = next_s;
            if (next_s == '0) begin
              maj_d = MAJ_TIE_VALUE;
            end else begin
              maj_d = ~next_s[LW];
            end
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (m_ready_in) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, remaining counter and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      maj_q     <= 1'b0;
      tally_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      maj_q     <= maj_d;
      tally_q   <= tally_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready_out = s_ready_q;
  assign m_valid_out = m_valid_q;
  assign maj_out     = maj_q;
  assign tally_out   = tally_q;
  assign busy_out    = busy_q;

  // The internal count is only observed through next_s.
  logic unused_s;
  assign unused_s = ^count_s;

endmodule
